fetch_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 15 +
 rtl/pc_counter.sv | 44 ++++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the fetch stage.
package cpu_pkg;

    localparam int PC_W  = 4;
    localparam int INS_W = 16;

    localparam logic [PC_W-1:0]  RESET_PC = 4'h0;
    localparam logic [INS_W-1:0] HALT_INS = 16'h0300;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter register: jump load, increment, hold, and a one-cycle
// WRAP pulse that follows an increment from the top address back to zero.
module pc_counter
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            jmp_en,
    input  logic [PC_W-1:0] jmp_addr,
    input  logic            inc_en,
    output logic [PC_W-1:0] pc,
    output logic            wrap
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic            wrap_q, wrap_d;

    // Next PC: a jump beats an increment; a jump to zero never flags a wrap.
    always_comb begin
        pc_d   = pc_q;
        wrap_d = 1'b0;
        if (jmp_en) begin
            pc_d = jmp_addr;
        end else if (inc_en) begin
            pc_d   = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
            wrap_d = (pc_q == {PC_W{1'b1}});
        end
    end

    // PC and WRAP registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            wrap_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            wrap_q <= wrap_d;
        end
    end

    assign pc   = pc_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: drives PC to instruction memory, captures the returned word
// into IR and offers it to the decoder over a valid/ready handshake.
// Handles jump flush, halt/resume and back-pressure.
// Optional macro SINGLE_STEP_EN adds a STEP input gating every load in RUN.
module fetch_unit
    import cpu_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_N,
    output logic [PC_W-1:0]  PC,
    input  logic [INS_W-1:0] RES_INS,
    output logic [INS_W-1:0] IR,
    output logic [PC_W-1:0]  IR_PC,
    output logic             IR_VALID,
    input  logic             IR_READY,
    input  logic             JMP_EN,
    input  logic [PC_W-1:0]  JMP_ADDR,
    input  logic             RESUME,
`ifdef SINGLE_STEP_EN
    input  logic             STEP,
`endif
    output logic             HALTED,
    output logic             WRAP
);

    fetch_state_t     state_q, state_d;
    logic [INS_W-1:0] ir_q, ir_d;
    logic [PC_W-1:0]  ir_pc_q, ir_pc_d;
    logic             ir_valid_q, ir_valid_d;

    logic             step_ok;
    logic             load;
    logic             accept;
    logic             is_halt;
    logic             inc_en;
    logic [PC_W-1:0]  pc;

`ifdef SINGLE_STEP_EN
    assign step_ok = STEP;
`else
    assign step_ok = 1'b1;
`endif

    // Handshake, load decision and next state; a jump flushes IR and overrides everything else.
    always_comb begin
        accept  = ir_valid_q & IR_READY;
        is_halt = (RES_INS == HALT_INS);
        load    = (state_q == RUN) & (~ir_valid_q | IR_READY) & ~JMP_EN & step_ok;
        inc_en  = (load & ~is_halt) | ((state_q == cpu_pkg::HALTED) & RESUME);

        state_d    = state_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;

        if (JMP_EN) begin
            state_d    = RUN;
            ir_valid_d = 1'b0;
        end else begin
            if (load) begin
                ir_d       = RES_INS;
                ir_pc_d    = pc;
                ir_valid_d = 1'b1;
                if (is_halt) begin
                    state_d = cpu_pkg::HALTED;
                end
            end else if (accept) begin
                ir_valid_d = 1'b0;
            end
            if ((state_q == cpu_pkg::HALTED) && RESUME) begin
                state_d = RUN;
            end
        end
    end

    // State and instruction register bank.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= RUN;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    pc_counter u_pc_counter (
        .clk      (CLK),
        .rst_n    (RST_N),
        .jmp_en   (JMP_EN),
        .jmp_addr (JMP_ADDR),
        .inc_en   (inc_en),
        .pc       (pc),
        .wrap     (WRAP)
    );

    assign PC       = pc;
    assign IR       = ir_q;
    assign IR_PC    = ir_pc_q;
    assign IR_VALID = ir_valid_q;
    assign HALTED   = (state_q == cpu_pkg::HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a small instruction memory answers PC
// combinationally; expected (address, word) pairs are queued when a scenario
// starts and popped whenever the decoder side accepts IR.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [3:0]  PC;
    logic [15:0] RES_INS;
    logic [15:0] IR;
    logic [3:0]  IR_PC;
    logic        IR_VALID;
    logic        IR_READY = 1'b1;
    logic        JMP_EN = 1'b0;
    logic [3:0]  JMP_ADDR = 4'h0;
    logic        RESUME = 1'b0;
    logic        STEP = 1'b1;
    logic        HALTED;
    logic        WRAP;

    logic [15:0] mem [16];

    typedef struct packed {
        logic [3:0]  pc;
        logic [15:0] ins;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 CLK = ~CLK;

    assign RES_INS = mem[PC];

    fetch_unit dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .PC       (PC),
        .RES_INS  (RES_INS),
        .IR       (IR),
        .IR_PC    (IR_PC),
        .IR_VALID (IR_VALID),
        .IR_READY (IR_READY),
        .JMP_EN   (JMP_EN),
        .JMP_ADDR (JMP_ADDR),
        .RESUME   (RESUME),
`ifdef SINGLE_STEP_EN
        .STEP     (STEP),
`endif
        .HALTED   (HALTED),
        .WRAP     (WRAP)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] a);
        exp_t e;
        e.pc  = a;
        e.ins = mem[a];
        exp_q.push_back(e);
    endtask

    // Leaves the bench 1 time unit after the edge that released reset;
    // the next edge is the first fetch.
    task automatic do_reset();
        JMP_EN   = 1'b0;
        RESUME   = 1'b0;
        IR_READY = 1'b1;
        STEP     = 1'b1;
        exp_q.delete();
        @(posedge CLK);
        #1 RST_N = 1'b0;
        @(posedge CLK);
        #1 RST_N = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge CLK);
        #1 RST_N = 1'b0;
        #2;
        total++;
        if (PC !== 4'h0) begin bad++; $display("[TB] FAIL reset_pc got=%h want=0", PC); end
        total++;
        if (IR !== 16'h0 || IR_PC !== 4'h0) begin bad++; $display("[TB] FAIL reset_ir got=%h/%h want=0/0", IR, IR_PC); end
        total++;
        if (IR_VALID !== 1'b0 || HALTED !== 1'b0 || WRAP !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_flags got v=%b h=%b w=%b want 0/0/0", IR_VALID, HALTED, WRAP);
        end
        @(posedge CLK);
        #1 RST_N = 1'b1;
    endtask

    task automatic test_sequential();
        exp_t e;
        do_reset();
        for (int a = 0; a < 7; a++) push_exp(4'(a));
        tick();
        for (int c = 1; c <= 7; c++) begin
            #2;
            total++;
            if (IR_VALID !== 1'b1) begin bad++; $display("[TB] FAIL seq_valid cycle=%0d got=%b want=1", c, IR_VALID); end
            if (IR_VALID && IR_READY) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("[TB] FAIL seq_sb got pc=%h want none", IR_PC); end
                else begin
                    e = exp_q.pop_front();
                    if (IR_PC !== e.pc || IR !== e.ins) begin
                        bad++; $display("[TB] FAIL seq_ir got=%h@%h want=%h@%h", IR, IR_PC, e.ins, e.pc);
                    end
                end
            end
            tick();
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL seq_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        exp_t e;
        do_reset();
        for (int a = 0; a < 5; a++) push_exp(4'(a));
        tick();
        for (int c = 1; c <= 8; c++) begin
            IR_READY = !(c >= 3 && c <= 5);
            #2;
            if (c >= 3 && c <= 5) begin
                total++;
                if (IR_PC !== 4'h2 || PC !== 4'h3 || IR !== mem[2] || IR_VALID !== 1'b1) begin
                    bad++; $display("[TB] FAIL bp_hold cycle=%0d got ir_pc=%h pc=%h want 2/3", c, IR_PC, PC);
                end
            end
            if (IR_VALID && IR_READY) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("[TB] FAIL bp_sb got pc=%h want none", IR_PC); end
                else begin
                    e = exp_q.pop_front();
                    if (IR_PC !== e.pc || IR !== e.ins) begin
                        bad++; $display("[TB] FAIL bp_ir got=%h@%h want=%h@%h", IR, IR_PC, e.ins, e.pc);
                    end
                end
            end
            tick();
        end
        IR_READY = 1'b1;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL bp_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_jump();
        exp_t e;
        do_reset();
        push_exp(4'h0); push_exp(4'h1); push_exp(4'h2); push_exp(4'hA); push_exp(4'hB);
        tick();
        for (int c = 1; c <= 6; c++) begin
            JMP_EN   = (c == 3);
            JMP_ADDR = 4'hA;
            #2;
            if (c == 4) begin
                total++;
                if (IR_VALID !== 1'b0 || PC !== 4'hA) begin
                    bad++; $display("[TB] FAIL jmp_flush got v=%b pc=%h want 0/a", IR_VALID, PC);
                end
            end
            if (IR_VALID && IR_READY) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("[TB] FAIL jmp_sb got pc=%h want none", IR_PC); end
                else begin
                    e = exp_q.pop_front();
                    if (IR_PC !== e.pc || IR !== e.ins) begin
                        bad++; $display("[TB] FAIL jmp_ir got=%h@%h want=%h@%h", IR, IR_PC, e.ins, e.pc);
                    end
                end
            end
            tick();
        end
        JMP_EN = 1'b0;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL jmp_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_halt();
        exp_t e;
        logic [15:0] saved;
        saved  = mem[7];
        mem[7] = 16'h0300;
        do_reset();
        for (int a = 0; a <= 8; a++) push_exp(4'(a));
        tick();
        for (int c = 1; c <= 11; c++) begin
            RESUME = (c == 9);
            #2;
            if (c == 8) begin
                total++;
                if (HALTED !== 1'b1 || PC !== 4'h7 || IR_PC !== 4'h7) begin
                    bad++; $display("[TB] FAIL halt_enter got h=%b pc=%h ir_pc=%h want 1/7/7", HALTED, PC, IR_PC);
                end
            end
            if (c == 9) begin
                total++;
                if (IR_VALID !== 1'b0 || HALTED !== 1'b1 || PC !== 4'h7) begin
                    bad++; $display("[TB] FAIL halt_hold got v=%b h=%b pc=%h want 0/1/7", IR_VALID, HALTED, PC);
                end
            end
            if (c == 10) begin
                total++;
                if (HALTED !== 1'b0 || PC !== 4'h8) begin
                    bad++; $display("[TB] FAIL halt_resume got h=%b pc=%h want 0/8", HALTED, PC);
                end
            end
            if (IR_VALID && IR_READY) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("[TB] FAIL halt_sb got pc=%h want none", IR_PC); end
                else begin
                    e = exp_q.pop_front();
                    if (IR_PC !== e.pc || IR !== e.ins) begin
                        bad++; $display("[TB] FAIL halt_ir got=%h@%h want=%h@%h", IR, IR_PC, e.ins, e.pc);
                    end
                end
            end
            tick();
        end
        RESUME = 1'b0;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL halt_left got=%0d want=0", exp_q.size()); end
        mem[7] = saved;
    endtask

    task automatic test_wrap();
        exp_t e;
        // Free-run across the top of the address space.
        do_reset();
        push_exp(4'h0); push_exp(4'hE); push_exp(4'hF); push_exp(4'h0); push_exp(4'h1);
        tick();
        for (int c = 1; c <= 6; c++) begin
            JMP_EN   = (c == 1);
            JMP_ADDR = 4'hE;
            #2;
            total++;
            if (WRAP !== (c == 4)) begin bad++; $display("[TB] FAIL wrap_pulse cycle=%0d got=%b want=%b", c, WRAP, (c == 4)); end
            if (IR_VALID && IR_READY) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("[TB] FAIL wrap_sb got pc=%h want none", IR_PC); end
                else begin
                    e = exp_q.pop_front();
                    if (IR_PC !== e.pc || IR !== e.ins) begin
                        bad++; $display("[TB] FAIL wrap_ir got=%h@%h want=%h@%h", IR, IR_PC, e.ins, e.pc);
                    end
                end
            end
            tick();
        end
        JMP_EN = 1'b0;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL wrap_left got=%0d want=0", exp_q.size()); end

        // A jump to address zero is not a wrap.
        do_reset();
        for (int a = 0; a < 5; a++) push_exp(4'(a));
        push_exp(4'h0); push_exp(4'h1);
        tick();
        for (int c = 1; c <= 8; c++) begin
            JMP_EN   = (c == 5);
            JMP_ADDR = 4'h0;
            #2;
            total++;
            if (WRAP !== 1'b0) begin bad++; $display("[TB] FAIL jmp0_wrap cycle=%0d got=%b want=0", c, WRAP); end
            if (IR_VALID && IR_READY) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("[TB] FAIL jmp0_sb got pc=%h want none", IR_PC); end
                else begin
                    e = exp_q.pop_front();
                    if (IR_PC !== e.pc || IR !== e.ins) begin
                        bad++; $display("[TB] FAIL jmp0_ir got=%h@%h want=%h@%h", IR, IR_PC, e.ins, e.pc);
                    end
                end
            end
            tick();
        end
        JMP_EN = 1'b0;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL jmp0_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_async_reset();
        exp_t e;
        do_reset();
        for (int a = 0; a < 8; a++) push_exp(4'(a));
        tick();
        for (int c = 1; c <= 8; c++) begin
            #2;
            if (IR_VALID && IR_READY) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("[TB] FAIL arst_sb got pc=%h want none", IR_PC); end
                else begin
                    e = exp_q.pop_front();
                    if (IR_PC !== e.pc || IR !== e.ins) begin
                        bad++; $display("[TB] FAIL arst_ir got=%h@%h want=%h@%h", IR, IR_PC, e.ins, e.pc);
                    end
                end
            end
            tick();
        end
        #2;
        total++;
        if (PC !== 4'h9 || IR_VALID !== 1'b1) begin bad++; $display("[TB] FAIL arst_pre got pc=%h v=%b want 9/1", PC, IR_VALID); end
        RST_N = 1'b0;
        #1;
        total++;
        if (PC !== 4'h0 || IR_VALID !== 1'b0 || IR !== 16'h0 || IR_PC !== 4'h0 || HALTED !== 1'b0 || WRAP !== 1'b0) begin
            bad++; $display("[TB] FAIL arst_now got pc=%h v=%b ir=%h ir_pc=%h want 0/0/0/0", PC, IR_VALID, IR, IR_PC);
        end
        tick();
        RST_N = 1'b1;
        exp_q.delete();
        push_exp(4'h0);
        tick();
        #2;
        total++;
        if (IR_VALID !== 1'b1) begin bad++; $display("[TB] FAIL arst_restart got v=%b want 1", IR_VALID); end
        if (IR_VALID && IR_READY) begin
            total++;
            if (exp_q.size() == 0) begin bad++; $display("[TB] FAIL arst_sb2 got pc=%h want none", IR_PC); end
            else begin
                e = exp_q.pop_front();
                if (IR_PC !== e.pc || IR !== e.ins) begin
                    bad++; $display("[TB] FAIL arst_ir2 got=%h@%h want=%h@%h", IR, IR_PC, e.ins, e.pc);
                end
            end
        end
        tick();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL arst_left got=%0d want=0", exp_q.size()); end
    endtask

`ifdef SINGLE_STEP_EN
    task automatic test_single_step();
        exp_t e;
        int   n_acc;
        n_acc = 0;
        do_reset();
        STEP = 1'b0;
        push_exp(4'h0); push_exp(4'h1); push_exp(4'h2);
        tick();
        for (int c = 1; c <= 10; c++) begin
            STEP     = (c == 2 || c == 5 || c == 7 || c == 8);
            IR_READY = !(c == 8 || c == 9);
            #2;
            if (IR_VALID && IR_READY) begin
                n_acc++;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("[TB] FAIL step_sb got pc=%h want none", IR_PC); end
                else begin
                    e = exp_q.pop_front();
                    if (IR_PC !== e.pc || IR !== e.ins) begin
                        bad++; $display("[TB] FAIL step_ir got=%h@%h want=%h@%h", IR, IR_PC, e.ins, e.pc);
                    end
                end
            end
            tick();
        end
        STEP     = 1'b0;
        IR_READY = 1'b1;
        #2;
        total++;
        if (n_acc != 3 || PC !== 4'h3 || IR_VALID !== 1'b0) begin
            bad++; $display("[TB] FAIL step_count got loads=%0d pc=%h v=%b want 3/3/0", n_acc, PC, IR_VALID);
        end
        STEP = 1'b1;
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'hA000 + 16'(i * 16'h0111);
        test_reset();
        test_sequential();
        test_backpressure();
        test_jump();
        test_halt();
        test_wrap();
        test_async_reset();
`ifdef SINGLE_STEP_EN
        test_single_step();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
